// File: rtl/tri_fifo_pkg.sv
// tri_fifo_pkg: shared FSM state type and sizing helper for the deskew bank
package tri_fifo_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, ERR} deskew_state_t;
   function automatic int row_idx_width(input int rows);
      return $clog2(rows);
   endfunction
endpackage

// File: rtl/tri_fifo_deskew_if.sv
// tri_fifo_deskew_if: skewed lane inputs and aligned row outputs of the deskew bank
interface tri_fifo_deskew_if
   import tri_fifo_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int TRI_LENGTH = 16,
   parameter int ROWS_PER_TILE = 16
);
   localparam int RW = row_idx_width(ROWS_PER_TILE);
   logic [TRI_LENGTH-1:0] enable_in;
   logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_in;
   logic valid_out;
   logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_out;
   logic [RW-1:0] row_idx;
   logic row_last;
   logic align_err;
   modport master(output enable_in, data_in, input valid_out, data_out, row_idx, row_last, align_err);
   modport slave(input enable_in, data_in, output valid_out, data_out, row_idx, row_last, align_err);
endinterface

// File: rtl/tri_delay_lane.sv
// tri_delay_lane: enable+data shift chain of DEPTH stages; DEPTH 0 is a wire-through
module tri_delay_lane #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic en_dly,
   output logic [DATA_WIDTH-1:0] data_dly
);
   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = clk | rst;
         assign en_dly = en;
         assign data_dly = data;
      end else begin : g_chain
         logic [DEPTH-1:0] en_q;
         logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
         // data shifts every cycle regardless of enable
         always_ff @(posedge clk) begin
            if (rst) begin
               en_q <= '0;
               data_q <= '0;
            end else begin
               en_q[0] <= en;
               data_q[0] <= data;
               for (int k = 1; k < DEPTH; k++) begin
                  en_q[k] <= en_q[k-1];
                  data_q[k] <= data_q[k-1];
               end
            end
         end
         assign en_dly = en_q[DEPTH-1];
         assign data_dly = data_q[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/tri_fifo_deskew.sv
// tri_fifo_deskew: realigns diagonally skewed lanes into rows with tile index and sticky misalignment flag
module tri_fifo_deskew
   import tri_fifo_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int TRI_LENGTH = 16,
   parameter int ROWS_PER_TILE = 16
) (
   input logic clk,
   input logic rst,
   tri_fifo_deskew_if.slave bus
);
   localparam int RW = row_idx_width(ROWS_PER_TILE);
   localparam logic [RW-1:0] LAST = RW'(ROWS_PER_TILE - 1);
   logic [TRI_LENGTH-1:0] e;
   logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] d;
   deskew_state_t state, state_n;
   logic [RW-1:0] cnt, cnt_n;
   logic full, mixed, take, wrap;
   genvar i;
   generate
      for (i = 0; i < TRI_LENGTH; i++) begin : g_lane
         tri_delay_lane #(.DATA_WIDTH(BIT_WIDTH), .DEPTH(TRI_LENGTH - 1 - i)) u_lane (
            .clk(clk),
            .rst(rst),
            .en(bus.enable_in[i]),
            .data(bus.data_in[i]),
            .en_dly(e[i]),
            .data_dly(d[i])
         );
      end
   endgenerate
   // cnt is the index the next aligned row will carry
   always_comb begin
      full = &e;
      mixed = |e & ~full;
      take = (state != ERR) && full;
      wrap = cnt == LAST;
      state_n = (state == ERR || mixed) ? ERR : take ? (wrap ? IDLE : COLLECT) : state;
      cnt_n = take ? (wrap ? '0 : cnt + RW'(1)) : cnt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bus.valid_out <= 1'b0;
         bus.data_out <= '0;
         bus.row_idx <= '0;
         bus.row_last <= 1'b0;
         bus.align_err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bus.valid_out <= take;
         bus.row_last <= take && wrap;
         bus.align_err <= state_n == ERR;
         if (take) begin
            bus.data_out <= d;
            bus.row_idx <= cnt;
         end
      end
   end
endmodule
